// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and default width for the HI/LO multiply/divide unit.
package muldiv_pkg;
   localparam int WIDTH_DEFAULT = 32;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (multiply) or restoring-subtract (divide) iteration.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  logic               div,
   output logic [2*WIDTH-1:0] acc_nx,
   output logic               q_bit
);
   logic [WIDTH:0] sum, shifted, diff;
   // Divide keeps {remainder, dividend}; the new quotient bit fills the vacated LSB in the top level.
   always_comb begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      shifted = acc[2*WIDTH-1:WIDTH-1];
      diff    = shifted - {1'b0, operand};
      q_bit   = div & ~diff[WIDTH];
      acc_nx  = div ? {q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                    : {sum, acc[WIDTH-1:1]};
   end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine producing HI/LO with a one-cycle load strobe.
module hilo_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic             HiLoLd,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic             DivZero
);
   localparam int CW = $clog2(WIDTH);
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [2*WIDTH-1:0] acc, step_acc, prod;
   logic [WIDTH-1:0] opnd, a_orig, a_mag, b_mag, quo, rem;
   logic is_div, neg_res, neg_rem, b_zero, q_bit, load, last;
   assign load   = Start && (state == S_IDLE || state == S_DONE);
   assign last   = cnt == CW'(WIDTH-1);
   assign a_mag  = (~Op[0] & A[WIDTH-1]) ? -A : A;
   assign b_mag  = (~Op[0] & B[WIDTH-1]) ? -B : B;
   assign prod   = neg_res ? -acc : acc;
   assign quo    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   assign Busy   = state == S_RUN || state == S_FIX;
   assign Done   = state == S_DONE;
   assign HiLoLd = Done;
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc    (acc),
      .operand(opnd),
      .div    (is_div),
      .acc_nx (step_acc),
      .q_bit  (q_bit)
   );
   always_ff @(posedge Clk) begin
      if (Clr) state <= S_IDLE;
      else     state <= state_nx;
   end
   always_comb begin
      state_nx = load ? S_RUN
               : state == S_RUN ? (last ? S_FIX : S_RUN)
               : state == S_FIX ? S_DONE
               : S_IDLE;
   end
   // Operands are captured as magnitudes; signs are reapplied only in FIX.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         cnt     <= '0;
         acc     <= '0;
         opnd    <= '0;
         a_orig  <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         b_zero  <= 1'b0;
         HiOut   <= '0;
         LoOut   <= '0;
         DivZero <= 1'b0;
      end else if (load) begin
         cnt     <= '0;
         acc     <= {{WIDTH{1'b0}}, Op[1] ? a_mag : b_mag};
         opnd    <= Op[1] ? b_mag : a_mag;
         a_orig  <= A;
         is_div  <= Op[1];
         neg_res <= ~Op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
         neg_rem <= ~Op[0] & A[WIDTH-1];
         b_zero  <= B == '0;
      end else if (state == S_RUN) begin
         acc <= step_acc | {{(2*WIDTH-1){1'b0}}, q_bit};
         cnt <= last ? '0 : cnt + 1'b1;
      end else if (state == S_FIX) begin
         HiOut   <= is_div ? (b_zero ? a_orig : rem) : prod[2*WIDTH-1:WIDTH];
         LoOut   <= is_div ? (b_zero ? '1 : quo) : prod[WIDTH-1:0];
         DivZero <= is_div & b_zero;
      end
   end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors with hand-computed HI/LO results, latency and abort checks.
module tb_hilo_muldiv_unit;
   import muldiv_pkg::*;
   logic        Clk = 1'b0;
   logic        Clr, Start, Busy, Done, HiLoLd, DivZero;
   logic [1:0]  Op;
   logic [31:0] A, B, HiOut, LoOut;
   int checks = 0;
   int failures = 0;
   hilo_muldiv_unit #(.WIDTH(32)) dut (
      .Clk    (Clk),
      .Clr    (Clr),
      .Start  (Start),
      .Op     (Op),
      .A      (A),
      .B      (B),
      .Busy   (Busy),
      .Done   (Done),
      .HiLoLd (HiLoLd),
      .HiOut  (HiOut),
      .LoOut  (LoOut),
      .DivZero(DivZero)
   );
   always #5 Clk = ~Clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // Called at a negedge; leaves the bench at the negedge after E0.
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      Op = op;
      A = a;
      B = b;
      Start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
   endtask
   // Waits for Done (bounded); inj >= 0 pulses a stray Start mid-run.
   task automatic wait_done(input string tag, input int inj, input logic [31:0] eh,
                            input logic [31:0] el, input logic edz);
      int i = 0;
      int busy = 0;
      while (!Done && i < 40) begin
         if (Busy) busy++;
         Start = (i == inj);
         if (i == inj) begin
            Op = OP_MULTU;
            A = 32'd7;
            B = 32'd9;
         end
         @(posedge Clk);
         @(negedge Clk);
         Start = 1'b0;
         i++;
      end
      check({tag, "_lat"}, i, 33);
      check({tag, "_busy"}, busy, 33);
      check({tag, "_done"}, {Done, HiLoLd, Busy}, 3'b110);
      check({tag, "_hi"}, HiOut, eh);
      check({tag, "_lo"}, LoOut, el);
      check({tag, "_dz"}, DivZero, edz);
   endtask
   task automatic idle_cycle(input string tag);
      @(posedge Clk);
      @(negedge Clk);
      check({tag, "_idle"}, {Done, HiLoLd, Busy}, 3'b000);
   endtask
   initial begin
      int pulses;
      Clr = 1'b1;
      Start = 1'b0;
      Op = '0;
      A = '0;
      B = '0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Clr = 1'b0;
      check("rst_ctl", {Busy, Done, HiLoLd, DivZero}, 4'b0000);
      check("rst_hilo", {HiOut, LoOut}, 64'h0);
      launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done("multu_max", -1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      idle_cycle("multu_max");
      check("hold_hi", HiOut, 32'hFFFFFFFE);
      launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
      wait_done("mult_neg", -1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      idle_cycle("mult_neg");
      launch(OP_MULT, 32'h80000000, 32'h80000000);
      wait_done("mult_min", -1, 32'h40000000, 32'h00000000, 1'b0);
      idle_cycle("mult_min");
      launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
      wait_done("div_neg", -1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      idle_cycle("div_neg");
      launch(OP_DIV, 32'd7, 32'hFFFFFFFE);
      wait_done("div_negb", -1, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      idle_cycle("div_negb");
      launch(OP_DIVU, 32'd100, 32'd7);
      wait_done("divu", -1, 32'd2, 32'd14, 1'b0);
      idle_cycle("divu");
      launch(OP_DIVU, 32'd100, 32'd0);
      wait_done("divu_z", -1, 32'h00000064, 32'hFFFFFFFF, 1'b1);
      idle_cycle("divu_z");
      check("dz_hold", DivZero, 1'b1);
      launch(OP_DIV, 32'hFFFFFFF8, 32'd0);
      wait_done("div_z", -1, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1);
      idle_cycle("div_z");
      launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_done("div_ovf", -1, 32'h00000000, 32'h80000000, 1'b0);
      idle_cycle("div_ovf");
      launch(OP_MULTU, 32'd5, 32'd6);
      wait_done("ign_start", 4, 32'd0, 32'd30, 1'b0);
      launch(OP_DIVU, 32'd100, 32'd7);
      wait_done("b2b", -1, 32'd2, 32'd14, 1'b0);
      idle_cycle("b2b");
      launch(OP_DIV, 32'd1000, 32'd3);
      repeat (9) begin
         @(posedge Clk);
         @(negedge Clk);
      end
      check("pre_clr_busy", Busy, 1'b1);
      Clr = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Clr = 1'b0;
      check("clr_busy", {Busy, Done, HiLoLd}, 3'b000);
      check("clr_hilo", {HiOut, LoOut}, 64'h0);
      pulses = 0;
      repeat (40) begin
         @(posedge Clk);
         @(negedge Clk);
         if (Done || HiLoLd || Busy) pulses++;
      end
      check("clr_no_done", pulses, 0);
      launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
      wait_done("after_clr", -1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
